// File: rtl/led_trail_pwm.sv
// LED comet-trail driver: lit channels are held at full brightness, and dark
// channels fade out through a shared PWM counter and a rate-selectable decay timer.
module led_trail_pwm #(
  parameter int unsigned N_LEDS       = 4,
  parameter int unsigned PWM_BITS     = 8,
  parameter int unsigned PWM_PRESCALE = 4,
  parameter int unsigned DECAY_TICKS  = 1_000_000,
  parameter int unsigned DECAY_STEP   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_LEDS-1:0] led_in,
  input  logic [1:0]        decay_sel,
  output logic [N_LEDS-1:0] led_out,
  output logic              pwm_sync
);

  localparam int unsigned PRE_W = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
  localparam int unsigned DEC_W = $clog2(DECAY_TICKS * 8) + 1;
  localparam logic [PWM_BITS-1:0] MAX      = '1;
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(PWM_PRESCALE - 1);

  logic [PRE_W-1:0]    pre_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [DEC_W-1:0]    dec_cnt;
  logic [DEC_W-1:0]    limit;
  logic [PWM_BITS-1:0] bright     [N_LEDS];
  logic [PWM_BITS-1:0] bright_nxt [N_LEDS];
  logic                pwm_tick;
  logic                pwm_wrap;
  logic                decay_tick;

  // The >= compare lets a shrinking limit fire immediately instead of wrapping.
  always_comb begin
    pwm_tick   = (pre_cnt == PRE_LAST);
    pwm_wrap   = pwm_tick && (pwm_cnt == MAX);
    limit      = DEC_W'(DECAY_TICKS) << decay_sel;
    decay_tick = (dec_cnt >= limit - DEC_W'(1));
  end

  always_comb begin
    for (int unsigned i = 0; i < N_LEDS; i++) begin
      bright_nxt[i] = bright[i];
      if (led_in[i]) begin
        bright_nxt[i] = MAX;
      end else if (decay_tick) begin
        bright_nxt[i] = (32'(bright[i]) > DECAY_STEP) ? bright[i] - PWM_BITS'(DECAY_STEP) : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt  <= '0;
      pwm_cnt  <= '0;
      dec_cnt  <= '0;
      led_out  <= '0;
      pwm_sync <= 1'b0;
      for (int unsigned i = 0; i < N_LEDS; i++) begin
        bright[i] <= '0;
      end
    end else begin
      pre_cnt  <= pwm_tick ? '0 : pre_cnt + 1'b1;
      if (pwm_tick) begin
        pwm_cnt <= pwm_cnt + 1'b1;
      end
      pwm_sync <= pwm_wrap;
      dec_cnt  <= decay_tick ? '0 : dec_cnt + 1'b1;
      for (int unsigned i = 0; i < N_LEDS; i++) begin
        bright[i]  <= bright_nxt[i];
        led_out[i] <= (bright[i] == MAX) || (pwm_cnt < bright[i]);
      end
    end
  end

endmodule

// File: tb/tb_led_trail_pwm.sv
// Scoreboard bench for led_trail_pwm: a cycle-count based reference model queues
// expected outputs, and a monitor pops them and compares once per clock.
module tb_led_trail_pwm;

  localparam int unsigned N    = 4;
  localparam int unsigned B    = 4;
  localparam int unsigned P    = 1;
  localparam int unsigned T    = 16;
  localparam int unsigned S    = 4;
  localparam int unsigned MAXV = (1 << B) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] led_in = '0;
  logic [1:0]   decay_sel = '0;
  logic [N-1:0] led_out;
  logic         pwm_sync;

  always #5 clk = ~clk;

  led_trail_pwm #(
    .N_LEDS(N),
    .PWM_BITS(B),
    .PWM_PRESCALE(P),
    .DECAY_TICKS(T),
    .DECAY_STEP(S)
  ) dut (
    .clk(clk),
    .rst(rst),
    .led_in(led_in),
    .decay_sel(decay_sel),
    .led_out(led_out),
    .pwm_sync(pwm_sync)
  );

  typedef struct packed {
    logic [N-1:0]   led;
    logic           sync;
    logic [N*B-1:0] br;
  } exp_t;

  exp_t        q[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference state: cycles since reset, cycle of last decay event, brightness.
  int unsigned m_c = 0;
  int unsigned m_last = 0;
  int unsigned m_b[N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  initial begin : model
    int unsigned pwm, pre, lim;
    bit          tick;
    exp_t        e;
    for (int i = 0; i < N; i++) m_b[i] = 0;
    forever begin
      @(posedge clk);
      e = '0;
      if (rst) begin
        m_c = 0;
        m_last = 0;
        for (int i = 0; i < N; i++) m_b[i] = 0;
      end else begin
        pwm    = (m_c / P) % (MAXV + 1);
        pre    = m_c % P;
        lim    = T << decay_sel;
        e.sync = (pwm == MAXV) && (pre == P - 1);
        for (int i = 0; i < N; i++) e.led[i] = (m_b[i] == MAXV) || (pwm < m_b[i]);
        tick = (m_c - m_last + 1 >= lim);
        for (int i = 0; i < N; i++) begin
          if (led_in[i]) m_b[i] = MAXV;
          else if (tick) m_b[i] = (m_b[i] > S) ? m_b[i] - S : 0;
        end
        if (tick) m_last = m_c + 1;
        m_c++;
      end
      for (int i = 0; i < N; i++) e.br[i*B +: B] = B'(m_b[i]);
      q.push_back(e);
    end
  end

  initial begin : monitor
    exp_t           e;
    logic [N*B-1:0] act_br;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        for (int i = 0; i < N; i++) act_br[i*B +: B] = dut.bright[i];
        check("led_out", 32'(led_out), 32'(e.led));
        check("pwm_sync", 32'(pwm_sync), 32'(e.sync));
        check("bright", 32'(act_br), 32'(e.br));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : driver
    bit found;
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(200);
    led_in = 4'b0001; cyc(500);
    led_in = 4'b0000; cyc(100);
    led_in = 4'b0010; cyc(40);
    led_in = 4'b0000; cyc(100);
    decay_sel = 2'd3;
    led_in = 4'b0010; cyc(40);
    led_in = 4'b0000; cyc(600);
    cyc(100);
    decay_sel = 2'd0; cyc(20);

    // Collision: relight channel 2 in the very cycle a decay event hits bright=7.
    led_in = 4'b0100; cyc(20);
    led_in = 4'b0000;
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      if (m_b[2] == 7 && (m_c - m_last + 1 >= (T << decay_sel))) begin
        found = 1'b1;
        led_in = 4'b0100;
      end
      cyc(1);
    end
    check("collision_reached", 32'(found), 32'd1);
    led_in = 4'b0000; cyc(30);

    // Reset in the middle of a fade.
    led_in = 4'b0010; cyc(40);
    led_in = 4'b0000;
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      if (m_b[1] == 7) found = 1'b1;
      else cyc(1);
    end
    check("midfade_reached", 32'(found), 32'd1);
    rst = 1'b1; cyc(1);
    rst = 1'b0; cyc(60);

    repeat (3000) begin
      if ($urandom_range(7) == 0) led_in = N'($urandom);
      if ($urandom_range(63) == 0) decay_sel = 2'($urandom);
      rst = ($urandom_range(499) == 0);
      cyc(1);
    end
    rst = 1'b0;
    cyc(3);
    check("queue_drained", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1);
  end

endmodule
